tick_monitor: RTL

- Downstream consumer of the periodic delay-counter stage; monitors its single-cycle `sig` pulse train.
- The upstream stage emits one `sig` pulse every N+1 cycles and raises `err` on counter overrun.
- This block measures the interval between consecutive pulses and classifies each interval as on-time, early or late.
- It counts consecutive bad intervals and raises a sticky alarm. The alarm feeds system-level fault handling and formal liveness checks.

---
 rtl/tick_mon_pkg.sv | 30 +++
 rtl/tick_monitor_gap_timer.sv | 43 ++++
 rtl/tick_monitor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tick_mon_pkg.sv
// ============================================================================
//  tick_mon_pkg
//  Shared types and default window constants for the tick monitor.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package tick_mon_pkg;

   // The upstream stage ticks every N+1 = 25001 cycles, centred in the window.
   localparam int MIN_GAP_DEF  = 25000;
   localparam int MAX_GAP_DEF  = 25002;
   localparam int MISS_LIM_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      ALARM = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CL_NONE  = 2'd0,
      CL_OK    = 2'd1,
      CL_EARLY = 2'd2,
      CL_LATE  = 2'd3
   } class_e;

endpackage

`default_nettype wire

// File: rtl/tick_monitor_gap_timer.sv
// ============================================================================
//  gap_timer
//  Interval counter; e is the elapsed-interval length (gap + 1).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gap_timer #(
   parameter int CBITS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CBITS:0]   e
);

   logic [CBITS-1:0] gap_q;
   logic [CBITS-1:0] gap_d;

   always_comb begin
      gap_d = gap_q;
      if (clear) begin
         gap_d = '0;
      end else if (enable) begin
         gap_d = gap_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end

   // One extra bit so gap + 1 never wraps back to a small value.
   assign e = {1'b0, gap_q} + (CBITS+1)'(1);

endmodule

`default_nettype wire

// File: rtl/tick_monitor.sv
// ============================================================================
//  tick_monitor
//  Classifies tick intervals as ok/early/late and raises a sticky alarm.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tick_monitor
   import tick_mon_pkg::*;
#(
   parameter int MIN_GAP  = MIN_GAP_DEF,
   parameter int MAX_GAP  = MAX_GAP_DEF,
   parameter int CBITS    = 16,
   parameter int MISS_LIM = MISS_LIM_DEF,
   parameter int TBITS    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig,
   input  logic             err_in,
   input  logic             clr,
   output logic             ok,
   output logic             early,
   output logic             late,
   output logic             alarm,
   output logic             running,
   output logic [TBITS-1:0] tick_cnt
);

   localparam int MBITS = (MISS_LIM < 2) ? 1 : $clog2(MISS_LIM + 1);
   localparam logic [CBITS:0]   MIN_E   = (CBITS+1)'(MIN_GAP);
   localparam logic [CBITS:0]   MAX_E   = (CBITS+1)'(MAX_GAP);
   localparam logic [MBITS-1:0] MISS_MX = MBITS'(MISS_LIM);

   state_e           state_q, state_d;
   logic [MBITS-1:0] miss_q, miss_d, miss_inc;
   logic [TBITS-1:0] tick_cnt_q, tick_cnt_d;
   logic             ok_q, ok_d;
   logic             early_q, early_d;
   logic             late_q, late_d;
   logic             alarm_q, alarm_d;
   logic             running_q, running_d;
   class_e           cls;
   logic             gap_clear;
   logic             gap_en;
   logic [CBITS:0]   e;

   gap_timer #(
      .CBITS (CBITS)
   ) u_gap_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (gap_clear),
      .enable (gap_en),
      .e      (e)
   );

   always_comb begin
      state_d    = state_q;
      miss_d     = miss_q;
      tick_cnt_d = tick_cnt_q;
      cls        = CL_NONE;
      gap_clear  = 1'b0;
      gap_en     = 1'b0;
      miss_inc   = (miss_q == MISS_MX) ? miss_q : miss_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (sig) begin
               gap_clear = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            // A timeout outranks a coincident tick and becomes the new reference.
            if (err_in) begin
               state_d = ALARM;
            end else if (e > MAX_E) begin
               cls = CL_LATE;
            end else if (sig && (e < MIN_E)) begin
               cls = CL_EARLY;
            end else if (sig) begin
               cls = CL_OK;
            end else begin
               gap_en = 1'b1;
            end

            if (cls == CL_OK) begin
               gap_clear  = 1'b1;
               miss_d     = '0;
               tick_cnt_d = tick_cnt_q + 1'b1;
            end else if ((cls == CL_EARLY) || (cls == CL_LATE)) begin
               gap_clear = 1'b1;
               miss_d    = miss_inc;
               if (miss_inc == MISS_MX) begin
                  state_d = ALARM;
               end
            end
         end
         ALARM: begin
            if (clr) begin
               state_d   = IDLE;
               gap_clear = 1'b1;
               miss_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ok_d      = (cls == CL_OK);
      early_d   = (cls == CL_EARLY);
      late_d    = (cls == CL_LATE);
      alarm_d   = (state_d == ALARM);
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         miss_q     <= '0;
         tick_cnt_q <= '0;
         ok_q       <= 1'b0;
         early_q    <= 1'b0;
         late_q     <= 1'b0;
         alarm_q    <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         miss_q     <= miss_d;
         tick_cnt_q <= tick_cnt_d;
         ok_q       <= ok_d;
         early_q    <= early_d;
         late_q     <= late_d;
         alarm_q    <= alarm_d;
         running_q  <= running_d;
      end
   end

   assign ok       = ok_q;
   assign early    = early_q;
   assign late     = late_q;
   assign alarm    = alarm_q;
   assign running  = running_q;
   assign tick_cnt = tick_cnt_q;

endmodule

`default_nettype wire
